nms_stream_controller: RTL and testbench
========================================

// Module: nms_stream_controller
// PURPOSE
//  Parametrised successor to the single-lane NMS controller. Buffers the last three gradient rows and
//  runs non-maximum suppression on LANES pixels per cycle across one COLS-wide strip.
//  Classifies each kept pixel strong/weak against run-time hysteresis thresholds.
//  Sits between the gradient stage and hysteresis/edge-link stage; adds warm-up tracking, pending-move latch, overrun flag.
// PARAMETERS
//  COLS   14  input strip width incl. 1-px left/right border; outputs are NOUT=COLS-2 wide
//  MAG_W  8   magnitude bits per pixel
//  LANES  1   pixels evaluated per cycle; NOUT % LANES == 0 (elaboration error otherwise)
// PORTS
//  clk             in   1            system clock, all state on posedge
//  n_rst           in   1            asynchronous active-low reset
//  anchor_moving   in   1            new gradient row valid on inputs this cycle (level, sampled per clk)
//  flush           in   1            sync clear of row buffer/warm-up, returns to IDLE
//  gradient_angle  in   COLS*2       row angles, pixel k at [2k+1:2k]; 0=0deg 1=45deg 2=90deg 3=135deg
//  gradient_mag    in   COLS*MAG_W   row magnitudes, pixel k at [k*MAG_W +: MAG_W]
//  low_thresh      in   MAG_W        weak threshold, sampled in COPY
//  high_thresh     in   MAG_W        strong threshold, sampled in COPY
//  nms_grad_angle  out  NOUT*2       angles of centre row cols 1..COLS-2
//  nms_out         out  NOUT*MAG_W   suppressed magnitudes
//  nms_strong      out  NOUT         1 = kept and mag >= high_thresh
//  nms_weak        out  NOUT         1 = kept, low_thresh <= mag < high_thresh
//  nms_valid       out  1            1-cycle pulse: full row of outputs now stable
//  nms_final       out  1            high in IDLE or during last lane group
//  overrun         out  1            sticky; set when a move arrives while one is already pending
// BEHAVIOUR
//  Reset/flush: state=IDLE, prime=0, pending=0, overrun=0, row buffer and all outputs 0, nms_final=1.
//  Row buffer r0(newest), r1(centre), r2(oldest); COPY: r2<=r1, r1<=r0, r0<=inputs; prime sat-incr to 3.
//  FSM: IDLE -anchor_moving|pending-> COPY -> PROC if prime(after incr)==3, else IDLE.
//   PROC: group counter g=0..NOUT/LANES-1, one group/cycle; after last group -> COPY if move/pending, else IDLE.
//  Latency: COPY 1 cycle + NOUT/LANES PROC cycles; nms_valid pulses the cycle after the last group is written.
//  Pending: anchor_moving in PROC (not last group) or COPY sets pending; consumed on next COPY entry.
//   anchor_moving with pending already set -> overrun=1 (sticky until reset/flush); extra row dropped.
//  Lane l of group g processes column c=g*LANES+l+1; 3x3 window rows r2,r1,r0, cols c-1..c+1.
//  Neighbour pair by r1 angle: 0: W/E (r1 c-1, c+1); 1: (r0 c-1, r2 c+1); 2: N/S (r2 c, r0 c);
//   3: (r2 c-1, r0 c+1). Keep when centre >= both neighbours (ties keep), else output 0.
//  Kept flags: strong if mag>=high; weak if low<=mag<high; both 0 if suppressed or mag<low.
//   If low>high: weak never set; strong uses high. Magnitude 0 never flagged.
//  Compares are unsigned MAG_W-bit, no arithmetic widening; border columns 0, COLS-1 never output.
//  Outputs for group g registered at end of its PROC cycle; untouched lanes hold previous row values.
//  nms_grad_angle = r1 cols 1..COLS-2, combinational from row buffer.
//  flush has priority over anchor_moving in same cycle; flush mid-PROC aborts, no nms_valid pulse.
//  n_rst mid-PROC: immediate return to reset values, partial row discarded.
// TESTING
//  Warm-up: 3 moves, 3 distinct rows -> first two COPYs return to IDLE, no nms_valid; third -> valid after 1+12 cycles (LANES=1).
//  Horizontal peak: r1 mags 10,50,10..., angle 0 -> nms_out[0]=50; equal neighbours 50,50,50 -> centre kept (tie).
//  Directional: angle 2, r2[c]=60, r1[c]=40 -> nms_out=0; angle 1 with r0[c-1]=30,r2[c+1]=20,r1=40 -> 40 kept.
//  Hysteresis: low=20 high=100, kept mags 15,20,99,100 -> flags none,weak,weak,strong.
//  Back-to-back: anchor_moving held high; LANES=4 -> valid every 4 cycles; extra move with pending set -> overrun=1.
//  Flush at g=5 -> IDLE next cycle, prime=0, no valid; n_rst low mid-PROC -> all outputs 0, nms_final=1.

Source files
------------

// File: rtl/nms_stream_controller_if.sv
// Stream bundle between the gradient stage and the NMS controller.
// Master is the gradient side; slave is the controller.
interface nms_stream_controller_if #(
    parameter int COLS  = 14,
    parameter int MAG_W = 8
);
    localparam int NOUT = COLS - 2;

    logic                    anchor_moving;
    logic                    flush;
    logic [COLS*2-1:0]       gradient_angle;
    logic [COLS*MAG_W-1:0]   gradient_mag;
    logic [MAG_W-1:0]        low_thresh;
    logic [MAG_W-1:0]        high_thresh;
    logic [NOUT*2-1:0]       nms_grad_angle;
    logic [NOUT*MAG_W-1:0]   nms_out;
    logic [NOUT-1:0]         nms_strong;
    logic [NOUT-1:0]         nms_weak;
    logic                    nms_valid;
    logic                    nms_final;
    logic                    overrun;

    modport master (
        output anchor_moving, flush, gradient_angle, gradient_mag, low_thresh, high_thresh,
        input  nms_grad_angle, nms_out, nms_strong, nms_weak, nms_valid, nms_final, overrun
    );

    modport slave (
        input  anchor_moving, flush, gradient_angle, gradient_mag, low_thresh, high_thresh,
        output nms_grad_angle, nms_out, nms_strong, nms_weak, nms_valid, nms_final, overrun
    );
endinterface

// File: rtl/nms_stream_controller.sv
// Three-row NMS controller: buffers gradient rows and suppresses LANES pixels per cycle
// across the strip, tagging kept pixels strong/weak against the hysteresis thresholds.
module nms_lane #(
    parameter int MAG_W = 8
) (
    input  logic [1:0]       i_ang,
    input  logic [MAG_W-1:0] i_nw, i_n, i_ne,
    input  logic [MAG_W-1:0] i_w,  i_c, i_e,
    input  logic [MAG_W-1:0] i_sw, i_s, i_se,
    input  logic [MAG_W-1:0] i_lo,
    input  logic [MAG_W-1:0] i_hi,
    output logic [MAG_W-1:0] o_mag,
    output logic             o_strong,
    output logic             o_weak
);
    logic [MAG_W-1:0] w_a, w_b;
    logic             w_keep, w_nz;

    // North is the oldest row (r2), south the newest (r0)
    always_comb begin
        w_a = i_w;
        w_b = i_e;
        unique case (i_ang)
            2'd0: begin w_a = i_w;  w_b = i_e;  end
            2'd1: begin w_a = i_sw; w_b = i_ne; end
            2'd2: begin w_a = i_n;  w_b = i_s;  end
            2'd3: begin w_a = i_nw; w_b = i_se; end
            default: begin w_a = i_w; w_b = i_e; end
        endcase
    end

    assign w_keep   = (i_c >= w_a) && (i_c >= w_b);
    assign w_nz     = |i_c;
    assign o_mag    = w_keep ? i_c : '0;
    assign o_strong = w_keep && w_nz && (i_c >= i_hi);
    assign o_weak   = w_keep && w_nz && (i_c >= i_lo) && (i_c < i_hi);
endmodule

module nms_stream_controller #(
    parameter int COLS  = 14,
    parameter int MAG_W = 8,
    parameter int LANES = 1
) (
    input logic                     clk,
    input logic                     n_rst,
    nms_stream_controller_if.slave  bus
);
    localparam int NOUT = COLS - 2;
    localparam int NGRP = NOUT / LANES;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int CW   = $clog2(COLS);

    generate
        if (NOUT % LANES != 0) begin : g_bad_lanes
            $error("nms_stream_controller: COLS-2 must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_PROC} state_t;

    state_t                         r_state, w_next;
    logic [GW-1:0]                  r_grp;
    logic [1:0]                     r_prime;
    logic                           r_pending, r_overrun, r_valid;
    logic [COLS-1:0][MAG_W-1:0]     r_mag0, r_mag1, r_mag2;
    logic [COLS-1:0][1:0]           r_ang0, r_ang1;
    logic [MAG_W-1:0]               r_lo, r_hi;
    logic [NOUT-1:0][MAG_W-1:0]     r_out;
    logic [NOUT-1:0]                r_strong, r_weak;

    logic                           w_last, w_move;
    logic [1:0]                     w_prime_inc;
    logic [LANES-1:0][MAG_W-1:0]    w_lmag;
    logic [LANES-1:0]               w_lstr, w_lwk;

    assign w_move      = bus.anchor_moving;
    assign w_last      = (r_grp == GW'(NGRP - 1));
    assign w_prime_inc = (r_prime == 2'd3) ? 2'd3 : r_prime + 2'd1;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_move || r_pending) w_next = S_COPY;
            S_COPY:  w_next = (w_prime_inc == 2'd3) ? S_PROC : S_IDLE;
            S_PROC:  if (w_last) w_next = (w_move || r_pending) ? S_COPY : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A move that cannot be taken straight into COPY is parked; a second one is dropped
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_grp     <= '0;
            r_prime   <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
        end else if (bus.flush) begin
            r_state   <= S_IDLE;
            r_grp     <= '0;
            r_prime   <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_grp   <= (r_state == S_PROC && !w_last) ? r_grp + GW'(1) : '0;
            r_valid <= (r_state == S_PROC) && w_last;
            if (r_state == S_COPY) r_prime <= w_prime_inc;
            if (w_next == S_COPY)  r_pending <= 1'b0;
            else if (w_move)       r_pending <= 1'b1;
            if (w_move && r_pending) r_overrun <= 1'b1;
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [CW-1:0] w_cc, w_cm, w_cp;
            assign w_cc = CW'(int'(r_grp) * LANES + l + 1);
            assign w_cm = w_cc - CW'(1);
            assign w_cp = w_cc + CW'(1);

            nms_lane #(.MAG_W(MAG_W)) u_lane (
                .i_ang    (r_ang1[w_cc]),
                .i_nw     (r_mag2[w_cm]), .i_n (r_mag2[w_cc]), .i_ne (r_mag2[w_cp]),
                .i_w      (r_mag1[w_cm]), .i_c (r_mag1[w_cc]), .i_e  (r_mag1[w_cp]),
                .i_sw     (r_mag0[w_cm]), .i_s (r_mag0[w_cc]), .i_se (r_mag0[w_cp]),
                .i_lo     (r_lo),
                .i_hi     (r_hi),
                .o_mag    (w_lmag[l]),
                .o_strong (w_lstr[l]),
                .o_weak   (w_lwk[l])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mag0   <= '0;
            r_mag1   <= '0;
            r_mag2   <= '0;
            r_ang0   <= '0;
            r_ang1   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_out    <= '0;
            r_strong <= '0;
            r_weak   <= '0;
        end else if (bus.flush) begin
            r_mag0   <= '0;
            r_mag1   <= '0;
            r_mag2   <= '0;
            r_ang0   <= '0;
            r_ang1   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_out    <= '0;
            r_strong <= '0;
            r_weak   <= '0;
        end else begin
            if (r_state == S_COPY) begin
                r_mag2 <= r_mag1;
                r_mag1 <= r_mag0;
                r_mag0 <= bus.gradient_mag;
                r_ang1 <= r_ang0;
                r_ang0 <= bus.gradient_angle;
                r_lo   <= bus.low_thresh;
                r_hi   <= bus.high_thresh;
            end
            // Only the current group's columns update; the rest hold the previous row
            if (r_state == S_PROC) begin
                for (int k = 0; k < NOUT; k++) begin
                    if (k / LANES == int'(r_grp)) begin
                        r_out[k]    <= w_lmag[k % LANES];
                        r_strong[k] <= w_lstr[k % LANES];
                        r_weak[k]   <= w_lwk[k % LANES];
                    end
                end
            end
        end
    end

    assign bus.nms_out        = r_out;
    assign bus.nms_strong     = r_strong;
    assign bus.nms_weak       = r_weak;
    assign bus.nms_grad_angle = r_ang1[COLS-2:1];
    assign bus.nms_valid      = r_valid;
    assign bus.overrun        = r_overrun;
    assign bus.nms_final      = (r_state == S_IDLE) || (r_state == S_PROC && w_last);
endmodule

// File: tb/tb_nms_stream_controller.sv
// Scoreboard bench: one 1-lane and one 4-lane controller share the same stimulus;
// expected rows are queued per instance and checked when each raises nms_valid.
module tb_nms_stream_controller;
    localparam int COLS  = 14;
    localparam int MAG_W = 8;
    localparam int NOUT  = COLS - 2;

    typedef struct {
        logic [NOUT*MAG_W-1:0] out;
        logic [NOUT-1:0]       st;
        logic [NOUT-1:0]       wk;
        logic [NOUT*2-1:0]     ang;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic anchor = 1'b0;
    logic flush = 1'b0;
    logic [COLS*2-1:0]     ang = '0;
    logic [COLS*MAG_W-1:0] mag = '0;
    logic [MAG_W-1:0]      lo = '0;
    logic [MAG_W-1:0]      hi = '0;

    exp_t q1[$], q4[$];
    exp_t e1, e4;
    int   t1[$], t4[$];
    int   nv1 = 0, nv4 = 0, cyc = 0;
    int   n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nms_stream_controller_if #(.COLS(COLS), .MAG_W(MAG_W)) if1 ();
    nms_stream_controller_if #(.COLS(COLS), .MAG_W(MAG_W)) if4 ();

    assign if1.anchor_moving  = anchor;
    assign if1.flush          = flush;
    assign if1.gradient_angle = ang;
    assign if1.gradient_mag   = mag;
    assign if1.low_thresh     = lo;
    assign if1.high_thresh    = hi;
    assign if4.anchor_moving  = anchor;
    assign if4.flush          = flush;
    assign if4.gradient_angle = ang;
    assign if4.gradient_mag   = mag;
    assign if4.low_thresh     = lo;
    assign if4.high_thresh    = hi;

    nms_stream_controller #(.COLS(COLS), .MAG_W(MAG_W), .LANES(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .bus(if1));
    nms_stream_controller #(.COLS(COLS), .MAG_W(MAG_W), .LANES(4)) u_dut4 (
        .clk(clk), .n_rst(n_rst), .bus(if4));

    // Hand-built rows (index = column)
    int RA_M[COLS] = '{0, 0, 0, 0, 0, 0, 60, 70, 20, 0, 0, 0, 0, 0};
    int RB_M[COLS] = '{10, 50, 10, 50, 50, 50, 40, 40, 25, 15, 20, 99, 100, 0};
    int RB_A[COLS] = '{0, 0, 0, 2, 0, 0, 2, 1, 3, 2, 2, 2, 2, 0};
    int RC_M[COLS] = '{0, 0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0, 0};
    int ZC[COLS]   = '{default: 0};
    int C80[COLS]  = '{default: 80};
    int E1_M[NOUT] = '{50, 0, 50, 50, 50, 0, 40, 0, 15, 20, 99, 100};
    int E1_A[NOUT] = '{0, 0, 2, 0, 0, 2, 1, 3, 2, 2, 2, 2};
    int E2_M[NOUT] = '{0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0};
    int O80[NOUT]  = '{default: 80};

    function automatic logic [COLS*MAG_W-1:0] row_m(input int v[COLS]);
        logic [COLS*MAG_W-1:0] r;
        for (int k = 0; k < COLS; k++) r[k*MAG_W +: MAG_W] = MAG_W'(v[k]);
        return r;
    endfunction

    function automatic logic [COLS*2-1:0] row_a(input int v[COLS]);
        logic [COLS*2-1:0] r;
        for (int k = 0; k < COLS; k++) r[k*2 +: 2] = 2'(v[k]);
        return r;
    endfunction

    function automatic logic [NOUT*MAG_W-1:0] out_m(input int v[NOUT]);
        logic [NOUT*MAG_W-1:0] r;
        for (int k = 0; k < NOUT; k++) r[k*MAG_W +: MAG_W] = MAG_W'(v[k]);
        return r;
    endfunction

    function automatic logic [NOUT*2-1:0] out_a(input int v[NOUT]);
        logic [NOUT*2-1:0] r;
        for (int k = 0; k < NOUT; k++) r[k*2 +: 2] = 2'(v[k]);
        return r;
    endfunction

    function automatic exp_t mk(input logic [NOUT*MAG_W-1:0] o, input logic [NOUT-1:0] s,
                                input logic [NOUT-1:0] w, input logic [NOUT*2-1:0] a);
        exp_t e;
        e.out = o; e.st = s; e.wk = w; e.ang = a;
        return e;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [NOUT*MAG_W-1:0] o,
                       input logic [NOUT-1:0] s, input logic [NOUT-1:0] w,
                       input logic [NOUT*2-1:0] a);
        check({nm, " nms_out"}, o, e.out);
        check({nm, " strong"}, s, e.st);
        check({nm, " weak"}, w, e.wk);
        check({nm, " angle"}, a, e.ang);
    endtask

    // Monitor: every valid pulse must match the oldest queued row
    always @(negedge clk) begin
        if (n_rst) begin
            if (if1.nms_valid) begin
                nv1++;
                t1.push_back(cyc);
                check("dut1 row expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    cmp("dut1", e1, if1.nms_out, if1.nms_strong, if1.nms_weak, if1.nms_grad_angle);
                end
            end
            if (if4.nms_valid) begin
                nv4++;
                t4.push_back(cyc);
                check("dut4 row expected", q4.size() > 0, 1);
                if (q4.size() > 0) begin
                    e4 = q4.pop_front();
                    cmp("dut4", e4, if4.nms_out, if4.nms_strong, if4.nms_weak, if4.nms_grad_angle);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic move(input logic [COLS*MAG_W-1:0] m, input logic [COLS*2-1:0] a,
                        input int l, input int h);
        mag = m; ang = a; lo = MAG_W'(l); hi = MAG_W'(h);
        anchor = 1'b1;
        tick();
        anchor = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e80;
        int lat1, lat4, s1, s4, d1, d4;
        e80 = mk(out_m(O80), '0, '1, '0);

        idle(3);
        n_rst = 1'b1;
        tick();
        check("reset final dut1", if1.nms_final, 1);
        check("reset final dut4", if4.nms_final, 1);
        check("reset valid dut1", if1.nms_valid, 0);
        check("reset overrun dut1", if1.overrun, 0);
        check("reset nms_out dut4", if4.nms_out, 0);

        // Warm-up: first two rows only prime the buffer
        move(row_m(RA_M), row_a(ZC), 20, 100);
        idle(14);
        move(row_m(RB_M), row_a(RB_A), 20, 100);
        idle(14);
        check("warmup no valid dut1", nv1, 0);
        check("warmup no valid dut4", nv4, 0);

        q1.push_back(mk(out_m(E1_M), 12'h800, 12'h65D, out_a(E1_A)));
        q4.push_back(mk(out_m(E1_M), 12'h800, 12'h65D, out_a(E1_A)));
        move(row_m(RC_M), row_a(ZC), 20, 100);
        lat1 = -1; lat4 = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (lat1 < 0 && if1.nms_valid) lat1 = i;
            if (lat4 < 0 && if4.nms_valid) lat4 = i;
            if (i == 5)  check("final mid-row dut1", if1.nms_final, 0);
            if (i == 11) check("final last group dut1", if1.nms_final, 1);
        end
        check("latency dut1", lat1, 12);
        check("latency dut4", lat4, 3);

        // low > high: only strong can be set
        q1.push_back(mk(out_m(E2_M), 12'h020, '0, '0));
        q4.push_back(mk(out_m(E2_M), 12'h020, '0, '0));
        move(row_m(ZC), row_a(ZC), 40, 30);
        idle(16);

        // zero thresholds: zero magnitudes still unflagged
        q1.push_back(mk('0, '0, '0, '0));
        q4.push_back(mk('0, '0, '0, '0));
        move(row_m(C80), row_a(ZC), 0, 0);
        idle(16);
        check("queue drained dut1", q1.size(), 0);
        check("queue drained dut4", q4.size(), 0);

        // Flush mid-row on the 1-lane instance (4-lane finishes first)
        s1 = nv1;
        q4.push_back(e80);
        move(row_m(C80), row_a(ZC), 20, 100);
        idle(3);
        check("partial row dut1", if1.nms_out[MAG_W-1:0], 80);
        check("final mid-row dut1 b", if1.nms_final, 0);
        idle(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush final dut1", if1.nms_final, 1);
        check("flush nms_out dut1", if1.nms_out, 0);
        check("flush nms_out dut4", if4.nms_out, 0);
        check("flush angle dut1", if1.nms_grad_angle, 0);
        idle(16);
        check("flush no valid dut1", nv1, s1);

        // Prime restarted: a single row yields nothing
        s1 = nv1; s4 = nv4;
        move(row_m(C80), row_a(ZC), 20, 100);
        idle(16);
        check("prime cleared dut1", nv1, s1);
        check("prime cleared dut4", nv4, s4);

        // Async reset mid-row
        q4.push_back(e80);
        move(row_m(C80), row_a(ZC), 20, 100);
        idle(3);
        move(row_m(C80), row_a(ZC), 20, 100);
        idle(5);
        check("partial row dut1 b", if1.nms_out[MAG_W-1:0], 80);
        n_rst = 1'b0;
        #1;
        check("reset mid nms_out dut1", if1.nms_out, 0);
        check("reset mid weak dut1", if1.nms_weak, 0);
        check("reset mid final dut1", if1.nms_final, 1);
        idle(2);
        n_rst = 1'b1;
        tick();
        check("queue drained dut1 b", q1.size(), 0);
        check("queue drained dut4 b", q4.size(), 0);

        // Back-to-back with anchor_moving held high
        for (int i = 0; i < 10; i++) q1.push_back(e80);
        for (int i = 0; i < 20; i++) q4.push_back(e80);
        t1.delete();
        t4.delete();
        mag = row_m(C80); ang = row_a(ZC); lo = 8'd20; hi = 8'd100;
        anchor = 1'b1;
        idle(60);
        check("b2b overrun dut1", if1.overrun, 1);
        check("b2b overrun dut4", if4.overrun, 1);
        d1 = (t1.size() >= 2) ? t1[t1.size()-1] - t1[t1.size()-2] : -1;
        d4 = (t4.size() >= 2) ? t4[t4.size()-1] - t4[t4.size()-2] : -1;
        check("b2b period dut1", d1, 13);
        check("b2b period dut4", d4, 4);
        anchor = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("flush clears overrun dut1", if1.overrun, 0);
        check("flush clears overrun dut4", if4.overrun, 0);
        q1.delete();
        q4.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
